// File: rtl/adc_frame_fifo_if.sv
// rtl/adc_frame_fifo_if.sv - stream bundle (tdata/tvalid/tready/tlast) shared by the ADC input and DMA output
interface adc_frame_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/adc_frame_fifo.sv
// rtl/adc_frame_fifo.sv - frame-aware FIFO that only releases whole ADC frames and drops frames that cannot fit
module adc_frame_fifo #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 10,
    parameter int MAX_FRAME_LEN = 512
) (
    input  logic                  aclk,
    input  logic                  areset,
    adc_frame_fifo_if.slave       s_axis,
    adc_frame_fifo_if.master      m_axis,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic [31:0]           frames_committed,
    output logic [15:0]           frames_dropped,
    output logic                  drop_active
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int FL_W  = $clog2(MAX_FRAME_LEN + 1);

    localparam logic [PW-1:0]   DEPTH_P = PW'(DEPTH);
    localparam logic [FL_W-1:0] MAX_LEN = FL_W'(MAX_FRAME_LEN);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);

    typedef enum logic {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_WIDTH:0]   r_mem [DEPTH];

    logic [PW-1:0]         r_wr_spec;
    logic [PW-1:0]         r_wr_commit;
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_fetch_ptr;
    logic [PW-1:0]         r_commit_q;
    logic [FL_W-1:0]       r_frame_len;
    logic [PW-1:0]         r_fill_level;
    logic [31:0]           r_frames_committed;
    logic [15:0]           r_frames_dropped;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_last;

    logic [PW-1:0]         w_spec_count;
    logic                  w_no_room;
    logic                  w_wr_en;
    logic                  w_reject;
    logic                  w_commit;
    logic                  w_len_clr;
    logic                  w_drop_active;
    logic                  w_pop;
    logic                  w_avail;
    logic                  w_fetch;
    logic [PW-1:0]         w_wr_commit_nxt;
    logic [PW-1:0]         w_rd_ptr_nxt;
    logic [DATA_WIDTH:0]   w_rd_word;

    // Space check uses pre-edge pointers: a word leaving this cycle does not free room for this cycle's write.
    // rd_ptr only advances on a downstream handshake, so the word parked in the output register still occupies space.
    assign w_spec_count = r_wr_spec - r_rd_ptr;
    assign w_no_room    = (w_spec_count == DEPTH_P) || (r_frame_len == MAX_LEN);

    // The ADC cannot be stalled.
    assign s_axis.tready = 1'b1;

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: enter DROP on a rejected non-final word, leave on the discarded frame's tlast.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_ACCEPT: if (s_axis.tvalid && w_no_room && !s_axis.tlast) w_state_nxt = ST_DROP;
            ST_DROP:   if (s_axis.tvalid && s_axis.tlast)              w_state_nxt = ST_ACCEPT;
            default:   w_state_nxt = ST_ACCEPT;
        endcase
    end

    // Per-word write actions derived from state and the incoming word.
    always_comb begin
        w_wr_en       = 1'b0;
        w_reject      = 1'b0;
        w_commit      = 1'b0;
        w_len_clr     = 1'b0;
        w_drop_active = (r_state == ST_DROP);
        case (r_state)
            ST_ACCEPT: begin
                if (s_axis.tvalid) begin
                    if (w_no_room) begin
                        w_reject  = 1'b1;
                        w_len_clr = s_axis.tlast;
                    end else begin
                        w_wr_en   = 1'b1;
                        w_commit  = s_axis.tlast;
                        w_len_clr = s_axis.tlast;
                    end
                end
            end
            ST_DROP: begin
                w_len_clr = s_axis.tvalid && s_axis.tlast;
            end
            default: ;
        endcase
    end

    assign w_wr_commit_nxt = w_commit ? (r_wr_spec + PTR_ONE) : r_wr_commit;

    // Speculative/committed write pointers, frame length and frame counters.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_spec          <= '0;
            r_wr_commit        <= '0;
            r_frame_len        <= '0;
            r_frames_committed <= '0;
            r_frames_dropped   <= '0;
        end else begin
            r_wr_commit <= w_wr_commit_nxt;
            if (w_reject) begin
                r_wr_spec <= r_wr_commit;
                if (r_frames_dropped != 16'hFFFF) r_frames_dropped <= r_frames_dropped + 16'd1;
            end else if (w_wr_en) begin
                r_wr_spec <= r_wr_spec + PTR_ONE;
            end
            if (w_commit) r_frames_committed <= r_frames_committed + 32'd1;
            if (w_len_clr) begin
                r_frame_len <= '0;
            end else if (w_wr_en) begin
                r_frame_len <= r_frame_len + FL_W'(1);
            end
        end
    end

    // Buffer write: tlast travels with each word.
    always_ff @(posedge aclk) begin
        if (w_wr_en) r_mem[r_wr_spec[ADDR_WIDTH-1:0]] <= {s_axis.tlast, s_axis.tdata};
    end

    // Fetch sees the commit pointer one cycle late, giving tvalid two edges after the committing tlast.
    assign w_pop        = r_out_valid && m_axis.tready;
    assign w_avail      = (r_fetch_ptr != r_commit_q);
    assign w_fetch      = w_avail && (!r_out_valid || m_axis.tready);
    assign w_rd_ptr_nxt = w_pop ? (r_rd_ptr + PTR_ONE) : r_rd_ptr;
    assign w_rd_word    = r_mem[r_fetch_ptr[ADDR_WIDTH-1:0]];

    // Read side: output register load/hold, read pointers and registered fill level.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_commit_q   <= '0;
            r_fetch_ptr  <= '0;
            r_rd_ptr     <= '0;
            r_fill_level <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
        end else begin
            r_commit_q   <= r_wr_commit;
            r_rd_ptr     <= w_rd_ptr_nxt;
            r_fill_level <= w_wr_commit_nxt - w_rd_ptr_nxt;
            if (w_fetch) begin
                r_fetch_ptr <= r_fetch_ptr + PTR_ONE;
                r_out_valid <= 1'b1;
                r_out_data  <= w_rd_word[DATA_WIDTH-1:0];
                r_out_last  <= w_rd_word[DATA_WIDTH];
            end else if (w_pop) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign m_axis.tvalid    = r_out_valid;
    assign m_axis.tdata     = r_out_data;
    assign m_axis.tlast     = r_out_last;
    assign fill_level       = r_fill_level;
    assign frames_committed = r_frames_committed;
    assign frames_dropped   = r_frames_dropped;
    assign drop_active      = w_drop_active;

endmodule

// File: doc/adc_frame_fifo.md
Name: adc_frame_fifo

Overview:
- Frame-aware buffer that sits directly downstream of the ADC block. It consumes the ADC's AXI-Stream output: 32-bit tdata, tvalid and tlast, with no tready because the ADC cannot be stalled.
- It stores whole frames and presents them to the DMA writer on an AXI-Stream master that has tready backpressure.
- A frame becomes visible to the reader only after its tlast word is written. If a frame cannot fit, the whole frame is dropped, so partial frames never reach memory.

Parameters:
- DATA_WIDTH, 32, stream word width.
- ADDR_WIDTH, 10, log2 of buffer depth; DEPTH = 2^ADDR_WIDTH words.
- MAX_FRAME_LEN, 512, longest accepted frame in words; longer frames are dropped.

Ports:
- aclk, input, 1, the single clock.
- areset, input, 1, synchronous active-high reset.
- s_axis_tvalid, input, 1, input word valid from the ADC; no tready exists.
- s_axis_tdata, input, DATA_WIDTH, input word.
- s_axis_tlast, input, 1, last word of the input frame.
- m_axis_tvalid, output, 1, output word valid.
- m_axis_tready, input, 1, downstream ready.
- m_axis_tdata, output, DATA_WIDTH, output word.
- m_axis_tlast, output, 1, last word of the output frame.
- fill_level, output, ADDR_WIDTH+1, committed words not yet read.
- frames_committed, output, 32, frames fully written.
- frames_dropped, output, 16, frames discarded for overflow or oversize; saturates at 0xFFFF.
- drop_active, output, 1, high while the current input frame is being discarded.

Behaviour:
- Clock and reset:
  - One clock, aclk.
  - areset is synchronous and active-high; it is sampled on the aclk rising edge.
  - Reset clears wr_spec, wr_commit, rd_ptr, frame_len, all counters and the output register.
  - Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, fill_level=0, frames_committed=0, frames_dropped=0, drop_active=0, state=ACCEPT.
  - Reset mid-frame discards the partial frame. The first word after reset starts a new frame.
- Storage:
  - Single RAM of DEPTH x (DATA_WIDTH+1); tlast is stored with each word.
  - Pointers are ADDR_WIDTH+1 bits so the full and empty cases are unambiguous.
  - All pointer arithmetic is modulo 2^(ADDR_WIDTH+1).
- Write side pointers:
  - wr_spec is the speculative write pointer; wr_commit is the committed pointer.
  - spec_count = wr_spec - rd_ptr, computed from pre-edge register values. A read in the same cycle does not create space for that cycle's write.
- State ACCEPT: on each cycle with s_axis_tvalid=1, one of the following applies, checked in order.
  1. Overflow or oversize:
     - Condition: spec_count == DEPTH, or frame_len == MAX_FRAME_LEN.
     - The word is not written; wr_spec rolls back to wr_commit; frames_dropped increments.
     - If tlast=1, state stays ACCEPT and frame_len is cleared. Otherwise state goes to DROP and drop_active=1.
  2. Normal word:
     - Write {tlast, tdata} at wr_spec; wr_spec increments; frame_len increments.
     - If tlast=1: wr_commit takes the new wr_spec value, frames_committed increments, frame_len clears.
- State DROP:
  - Input words are ignored.
  - On a tvalid word with tlast=1: state goes to ACCEPT, drop_active goes to 0, frame_len clears.
  - The dropped frame is counted once only, on DROP entry.
- Read side:
  - Words are readable only when rd_ptr != wr_commit.
  - One output register holds the word. A RAM read is issued when the output register is empty, or when it is full and m_axis_tready=1.
  - Holding rules: tdata and tlast are held stable while tvalid=1 and tready=0. tvalid never drops without a handshake.
  - Throughput is 1 word per cycle when tready is held high.
- Latency: a tlast word sampled at edge N, with the FIFO empty and the output register empty, gives wr_commit updated at N and m_axis_tvalid=1 after edge N+2.
- fill_level = wr_commit - rd_ptr, registered, and includes the word held in the output register.
- A 1-word frame (tvalid and tlast in the same cycle at frame start) is legal and is committed as a frame of length 1.
- Simultaneous write-commit and read in the same cycle are both performed.

Test Plan:
- ADDR_WIDTH=4, MAX_FRAME_LEN=8, tready=1. Send a 4-word frame 0x10..0x13 with tlast on 0x13 -> output 0x10..0x13 with tlast only on 0x13. First tvalid occurs 2 edges after the tlast edge. frames_committed=1.
- tready=0. Send frames of 8 and 8 words, then a 3-word frame -> the first two frames commit with fill_level=16. The third frame is dropped: frames_dropped=1, and drop_active is high for the 2 words after the first rejected word. After tready=1, exactly 16 words drain, with tlast on words 8 and 16.
- Send a 10-word frame with MAX_FRAME_LEN=8 -> frame dropped at word 9, frames_dropped=1, nothing output. A following 2-word frame is committed and output normally.
- Toggle tready randomly 50% during a 3-frame stream -> every word is output exactly once and in order. tdata and tlast are stable while tvalid=1 and tready=0.
- Assert areset for 1 cycle after word 3 of a 6-word frame -> counters, fill_level and tvalid are 0 on the next cycle. Remaining words 4..6 form a committed 3-word frame.
- Send back-to-back 1-word frames 0xA, 0xB, 0xC with tlast=1 on each -> 3 outputs, each with tlast=1, and frames_committed=3.
